mpnto1_rr: RTL and testbench
============================

MPNTO1_RR -- requirements
Module: mpnto1_rr

Interface
REQ-001 Parameter N, default 7, number of input channels (2..16).
REQ-002 Parameter W, default 7, data width per channel in bits (1..64).
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port in_data  input  unpacked array [0:N-1] of W bits  channel data words.
REQ-006 Port in_valid  input  N  per-channel data-valid.
REQ-007 Port in_ready  output  N  per-channel accept strobe.
REQ-008 Port mode  input  1  0 = fixed select, 1 = round-robin.
REQ-009 Port sel  input  $clog2(N)  channel index used when mode=0.
REQ-010 Port out_data  output  W  registered selected word.
REQ-011 Port out_ch  output  $clog2(N)  index of the channel that supplied out_data.
REQ-012 Port out_valid  output  1  out_data/out_ch hold a word.
REQ-013 Port out_ready  input  1  downstream accept.

Function
REQ-014 Output stage SHALL be a one-entry register with two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-015 load = !out_valid || out_ready; a transfer on the output occurs when out_valid && out_ready.
REQ-016 mode=0: grant = sel when sel<N and in_valid[sel]=1; otherwise no grant (sel>=N never grants, never indexes out of range).
REQ-017 mode=1: grant = first i with in_valid[i]=1, searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (wrap-around).
REQ-018 in_ready[i] SHALL be 1 only when load=1 and grant=i; at most one in_ready bit is high per cycle.
REQ-019 On load with a grant: out_data <= in_data[grant], out_ch <= grant, out_valid <= 1 on the next edge; latency is one cycle.
REQ-020 On load with no grant: out_valid <= 0; out_data and out_ch hold their previous values.
REQ-021 While FULL and out_ready=0: out_data, out_ch and out_valid SHALL hold, and in_ready SHALL be all-zero.
REQ-022 Simultaneous drain and refill (FULL, out_ready=1, grant present) SHALL sustain one word per cycle with no bubble.
REQ-023 Round-robin pointer ptr ($clog2(N) bits): on a granted load in mode=1, ptr <= (grant==N-1) ? 0 : grant+1; otherwise ptr holds.
REQ-024 A mode change takes effect in the same cycle; ptr SHALL NOT be modified while mode=0.
REQ-025 in_data of non-granted channels SHALL have no effect on any output.

Reset
REQ-026 While rst_n=0 at a clock edge: out_valid=0, out_data=0, out_ch=0, ptr=0 after that edge.
REQ-027 While rst_n=0, in_ready SHALL be all-zero, regardless of in_valid.
REQ-028 Reset asserted while FULL SHALL discard the held word with no output transfer.

Structure
REQ-029 A shared package mpnto1_pkg SHALL hold the mode encodings MODE_FIXED=0 and MODE_RR=1, plus a function returning the next round-robin index with wrap.
REQ-030 The round-robin search SHALL be one sub-module, rr_pick (inputs: req[N], ptr; outputs: gnt_idx, gnt_vld), purely combinational; all state stays in mpnto1_rr.

Verification
REQ-031 Reset: rst_n=0 for 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, in_ready=0.
REQ-032 Fixed mode, N=7, W=7: in_data[i]=7'h10+i, all valid, out_ready=1, sel stepped 0..6 every cycle -> out_data = 7'h10..7'h16 and out_ch = 0..6, each one cycle after the corresponding sel.
REQ-033 Fixed mode with sel=3 and in_valid[3]=0 -> out_valid=0, in_ready=0. With sel=7 -> no grant.
REQ-034 Round-robin, all valid, out_ready=1 for 9 cycles -> out_ch sequence 0,1,2,3,4,5,6,0,1.
REQ-035 Backpressure: FULL with out_ch=2, out_ready=0 for 3 cycles -> outputs stable and in_ready=0; then out_ready=1 -> next out_ch=3 with no bubble.
REQ-036 Sparse round-robin: in_valid=7'b1000010 from ptr=2 -> grants 6, 1, 6; then rst_n=0 mid-stream -> out_valid=0 and ptr=0 on the next cycle.

Source files
------------

// File: rtl/mpnto1_pkg.sv
// Shared definitions for the N-to-1 multiplexer: mode encodings, output-stage
// states and the wrap-around round-robin successor.
package mpnto1_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } ostate_e;

   function automatic int rr_next(input int idx, input int n);
      return (idx == n - 1) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/mpnto1_rr_pick.sv
// Combinational round-robin search: first asserted req at or after ptr, wrapping
// past N-1 back to 0. No state, zero latency.
module rr_pick #(
   parameter int N  = 7,
   parameter int SW = 3
) (
   input  logic [N-1:0]  req,
   input  logic [SW-1:0] ptr,
   output logic [SW-1:0] gnt_idx,
   output logic          gnt_vld
);

   int idx;

   always_comb begin
      gnt_idx = '0;
      gnt_vld = 1'b0;
      idx     = 0;
      for (int k = 0; k < N; k++) begin
         idx = int'(ptr) + k;
         if (idx >= N) idx = idx - N;
         if (!gnt_vld && idx < N && req[idx]) begin
            gnt_vld = 1'b1;
            gnt_idx = SW'(idx);
         end
      end
   end

endmodule

// File: rtl/mpnto1_rr.sv
// N-to-1 multiplexer (fixed select or round-robin) into a one-entry output register.
// One-cycle latency; full-throughput drain/refill; in_ready stays low while the held word is stalled.
module mpnto1_rr import mpnto1_pkg::*; #(
   parameter int N = 7,
   parameter int W = 7,
   localparam int SW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [W-1:0]  in_data [0:N-1],
   input  logic [N-1:0]  in_valid,
   output logic [N-1:0]  in_ready,
   input  logic          mode,
   input  logic [SW-1:0] sel,
   output logic [W-1:0]  out_data,
   output logic [SW-1:0] out_ch,
   output logic          out_valid,
   input  logic          out_ready
);

   ostate_e       state_q, state_d;
   logic [W-1:0]  data_q, data_d;
   logic [SW-1:0] ch_q, ch_d;
   logic [SW-1:0] ptr_q, ptr_d;

   logic          load;
   logic          fix_vld;
   logic          rr_vld;
   logic [SW-1:0] rr_idx;
   logic          gnt_vld;
   logic [SW-1:0] gnt_idx;
   logic [W-1:0]  gnt_data;

   rr_pick #(.N(N), .SW(SW)) u_pick (
      .req     (in_valid),
      .ptr     (ptr_q),
      .gnt_idx (rr_idx),
      .gnt_vld (rr_vld)
   );

   // Compare rather than index so an out-of-range sel can never grant.
   always_comb begin
      fix_vld = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (int'(sel) == i && in_valid[i]) fix_vld = 1'b1;
      end
   end

   assign load    = (state_q == ST_EMPTY) || out_ready;
   assign gnt_vld = (mode == MODE_RR) ? rr_vld : fix_vld;
   assign gnt_idx = (mode == MODE_RR) ? rr_idx : sel;

   always_comb begin
      gnt_data = '0;
      in_ready = '0;
      for (int i = 0; i < N; i++) begin
         if (int'(gnt_idx) == i) begin
            gnt_data    = in_data[i];
            in_ready[i] = rst_n && load && gnt_vld;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      ch_d    = ch_q;
      ptr_d   = ptr_q;
      if (load) begin
         if (gnt_vld) begin
            state_d = ST_FULL;
            data_d  = gnt_data;
            ch_d    = gnt_idx;
            if (mode == MODE_RR) ptr_d = SW'(rr_next(int'(gnt_idx), N));
         end else begin
            state_d = ST_EMPTY;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_EMPTY;
         data_q  <= '0;
         ch_q    <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         ch_q    <= ch_d;
         ptr_q   <= ptr_d;
      end
   end

   assign out_valid = (state_q == ST_FULL);
   assign out_data  = data_q;
   assign out_ch    = ch_q;

endmodule

// File: tb/tb_mpnto1_rr.sv
// Bench for mpnto1_rr: directed vector table, hand sequences for multi-cycle
// corners, then random traffic against a behavioural reference model.
module tb_mpnto1_rr;

   localparam int N  = 7;
   localparam int W  = 7;
   localparam int SW = $clog2(N);

   logic          clk = 1'b0;
   logic          rst_n;
   logic [W-1:0]  in_data [0:N-1];
   logic [N-1:0]  in_valid;
   logic [N-1:0]  in_ready;
   logic          mode;
   logic [SW-1:0] sel;
   logic [W-1:0]  out_data;
   logic [SW-1:0] out_ch;
   logic          out_valid;
   logic          out_ready;

   int total = 0;
   int bad   = 0;

   bit           m_vld;
   int           m_data;
   int           m_ch;
   int           m_ptr;
   logic [N-1:0] rdy_pre;

   typedef struct {
      logic          md;
      logic [SW-1:0] sl;
      logic [N-1:0]  vm;
      logic          ordy;
      logic [N-1:0]  e_rdy;
      logic          e_vld;
      int            e_ch;
      int            e_data;
   } vec_t;

   vec_t tbl [9];

   always #5 clk = ~clk;

   mpnto1_rr #(.N(N), .W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mode      (mode),
      .sel       (sel),
      .out_data  (out_data),
      .out_ch    (out_ch),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int ref_grant();
      if (mode == 1'b0) begin
         if (int'(sel) < N) begin
            if (in_valid[sel]) return int'(sel);
         end
         return -1;
      end
      for (int k = 0; k < N; k++) begin
         if (in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
      end
      return -1;
   endfunction

   // One clock: check in_ready before the edge, advance the model, check outputs after it.
   task automatic step();
      int           g;
      bit           ld;
      logic [N-1:0] exp_rdy;
      #1;
      g  = ref_grant();
      ld = !m_vld || out_ready;
      exp_rdy = '0;
      if (rst_n && ld && g >= 0) exp_rdy[g] = 1'b1;
      rdy_pre = in_ready;
      chk("model_in_ready", int'(in_ready), int'(exp_rdy));
      @(posedge clk);
      if (!rst_n) begin
         m_vld = 0; m_data = 0; m_ch = 0; m_ptr = 0;
      end else if (ld) begin
         if (g >= 0) begin
            m_vld  = 1;
            m_data = int'(in_data[g]);
            m_ch   = g;
            if (mode) m_ptr = (g + 1) % N;
         end else begin
            m_vld = 0;
         end
      end
      #1;
      chk("model_out_valid", int'(out_valid), int'(m_vld));
      chk("model_out_data", int'(out_data), m_data);
      chk("model_out_ch", int'(out_ch), m_ch);
   endtask

   task automatic chk_out(input string name, input int vld, input int ch, input int data);
      chk({name, "_valid"}, int'(out_valid), vld);
      chk({name, "_ch"}, int'(out_ch), ch);
      chk({name, "_data"}, int'(out_data), data);
   endtask

   initial begin
      int exp_seq [3];
      m_vld = 0; m_data = 0; m_ch = 0; m_ptr = 0;

      for (int i = 0; i < N; i++) tbl[i] = '{1'b0, SW'(i), 7'h7f, 1'b1, N'(1 << i), 1'b1, i, 'h10 + i};
      tbl[7] = '{1'b0, 3'd3, 7'b1110111, 1'b1, 7'b0, 1'b0, 6, 'h16};
      tbl[8] = '{1'b0, 3'd7, 7'h7f, 1'b1, 7'b0, 1'b0, 6, 'h16};

      rst_n     = 1'b0;
      mode      = 1'b0;
      sel       = '0;
      in_valid  = '1;
      out_ready = 1'b1;
      for (int i = 0; i < N; i++) in_data[i] = W'('h10 + i);

      // Reset with every channel requesting.
      for (int c = 0; c < 2; c++) begin
         step();
         chk("reset_in_ready", int'(rdy_pre), 0);
         chk_out("reset", 0, 0, 0);
      end
      rst_n = 1'b1;

      for (int i = 0; i < 9; i++) begin
         mode      = tbl[i].md;
         sel       = tbl[i].sl;
         in_valid  = tbl[i].vm;
         out_ready = tbl[i].ordy;
         step();
         chk("tbl_in_ready", int'(rdy_pre), int'(tbl[i].e_rdy));
         chk_out("tbl", int'(tbl[i].e_vld), tbl[i].e_ch, tbl[i].e_data);
      end

      // Round-robin over all channels from ptr=0.
      mode = 1'b1; in_valid = '1; out_ready = 1'b1;
      for (int k = 0; k < 9; k++) begin
         step();
         chk_out("rr_seq", 1, k % N, 'h10 + (k % N));
      end

      // Backpressure while holding channel 2, then refill with no bubble.
      step();
      chk_out("bp_load", 1, 2, 'h12);
      out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         step();
         chk("bp_in_ready", int'(rdy_pre), 0);
         chk_out("bp_hold", 1, 2, 'h12);
      end
      out_ready = 1'b1;
      step();
      chk("bp_release_rdy", int'(rdy_pre), 'b0001000);
      chk_out("bp_release", 1, 3, 'h13);

      // Sparse round-robin: grant 1 leaves ptr=2, then mask 1000010 alternates 6 and 1.
      in_valid = 7'b0000010;
      step();
      chk_out("sparse_pre", 1, 1, 'h11);
      in_valid = 7'b1000010;
      exp_seq = '{6, 1, 6};
      for (int k = 0; k < 3; k++) begin
         step();
         chk_out("sparse", 1, exp_seq[k], 'h10 + exp_seq[k]);
      end
      step();
      chk_out("sparse_post", 1, 1, 'h11);
      rst_n = 1'b0;
      step();
      chk("midrst_in_ready", int'(rdy_pre), 0);
      chk_out("midrst", 0, 0, 0);
      rst_n = 1'b1; in_valid = '1;
      step();
      chk_out("ptr_after_rst", 1, 0, 'h10);

      // Random traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         rst_n     = ($urandom_range(0, 63) != 0);
         if ($urandom_range(0, 7) == 0) mode = 1'($urandom_range(0, 1));
         sel       = SW'($urandom_range(0, 7));
         in_valid  = N'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < N; i++) in_data[i] = W'($urandom);
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
